// File: rtl/eth1_cfgen1.sv
// SPI-loaded arbitrary waveform generator: 256x14 sample RAM played back onto an AD9744 DAC bus.
// SPI runs CPOL=0/CPHA=1 on 32-bit words {cmd[3:0], addr[13:0], data[13:0]}.
module eth1_cfgen1 #(
  parameter int unsigned DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SCK,
  input  logic        MOSI,
  input  logic        SSEL,
  output logic        MISO,
  output logic [13:0] wd,
  output logic [7:0]  LED_out,
  output logic        test_rx_valid,
  output logic        test_clk_valid,
  output logic [31:0] test_spi_rx_data,
  output logic        test_fifo_wr_en,
  output logic        test_fifo_wr_ack,
  output logic [13:0] test_fifo_din,
  output logic [7:0]  test_fifo_wr_data_count,
  output logic [7:0]  test_count,
  output logic        test_fifo_almost_full,
  output logic        test_fifo_full,
  output logic [7:0]  test_samples
);

  localparam int unsigned DW   = 14;
  localparam int unsigned AW   = 8;
  localparam int unsigned WW   = 32;
  localparam int unsigned BW   = 5;
  localparam int unsigned DEPTH = 256;
  localparam logic [DW-1:0] MIDSCALE = 14'h2000;
  localparam logic [3:0] CMD_WRITE = 4'd1;
  localparam logic [3:0] CMD_START = 4'd2;
  localparam logic [3:0] CMD_STOP  = 4'd3;
  localparam logic [3:0] CMD_CLEAR = 4'd4;

  // Startup holdoff: SPI is ignored until 16 clocks after reset release
  logic [3:0] boot_cnt;
  logic       clk_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_cnt  <= '0;
      clk_valid <= 1'b0;
    end else if (!clk_valid) begin
      boot_cnt  <= boot_cnt + 4'd1;
      clk_valid <= (boot_cnt == 4'd15);
    end
  end

  // Two-flop synchronizers for the SPI pins; SCK gets a third stage for edge detection
  logic [2:0] sck_q;
  logic [1:0] mosi_q;
  logic [1:0] ssel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= '0;
      mosi_q <= '0;
      ssel_q <= '1;
    end else begin
      sck_q  <= {sck_q[1:0], SCK};
      mosi_q <= {mosi_q[0], MOSI};
      ssel_q <= {ssel_q[0], SSEL};
    end
  end

  logic sck_rise_c;
  logic sck_fall_c;
  assign sck_rise_c = clk_valid &  sck_q[1] & ~sck_q[2];
  assign sck_fall_c = clk_valid & ~sck_q[1] &  sck_q[2];

  logic [BW-1:0] bit_cnt;
  logic [WW-1:0] rx_sh;
  logic [WW-1:0] tx_sh;
  logic [WW-1:0] rx_word;
  logic          rx_valid;
  logic          miso_r;

  // Receive on SCK fall, transmit previous word on SCK rise; a completed word reloads tx
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      rx_sh    <= '0;
      tx_sh    <= '0;
      rx_word  <= '0;
      rx_valid <= 1'b0;
      miso_r   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (ssel_q[1]) begin
        bit_cnt <= '0;
        miso_r  <= 1'b0;
        tx_sh   <= rx_word;
      end else begin
        if (sck_rise_c) begin
          miso_r <= tx_sh[WW-1];
          tx_sh  <= {tx_sh[WW-2:0], 1'b0};
        end
        if (sck_fall_c) begin
          rx_sh <= {rx_sh[WW-2:0], mosi_q[1]};
          if (bit_cnt == BW'(WW - 1)) begin
            bit_cnt  <= '0;
            rx_word  <= {rx_sh[WW-2:0], mosi_q[1]};
            tx_sh    <= {rx_sh[WW-2:0], mosi_q[1]};
            rx_valid <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
      end
    end
  end

  logic [3:0]    cmd_c;
  logic [AW-1:0] waddr_c;
  logic [DW-1:0] wdata_c;
  logic          is_wr_c;
  logic          is_start_c;
  logic          is_stop_c;
  logic          is_clear_c;

  assign cmd_c      = rx_word[31:28];
  assign waddr_c    = rx_word[21:14];
  assign wdata_c    = rx_word[13:0];
  assign is_wr_c    = rx_valid && (cmd_c == CMD_WRITE);
  assign is_start_c = rx_valid && (cmd_c == CMD_START);
  assign is_stop_c  = rx_valid && (cmd_c == CMD_STOP);
  assign is_clear_c = rx_valid && (cmd_c == CMD_CLEAR);

  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] wr_cnt_nxt_c;
  logic [AW-1:0] samples;
  logic          wr_en;
  logic          wr_ack;
  logic [DW-1:0] din;
  logic          afull;
  logic          full;

  always_comb begin
    wr_cnt_nxt_c = wr_cnt;
    if (is_clear_c) begin
      wr_cnt_nxt_c = '0;
    end else if (is_wr_c && (wr_cnt != '1)) begin
      wr_cnt_nxt_c = wr_cnt + AW'(1);
    end
  end

  // Write bookkeeping; fill flags track the registered count exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      samples <= '0;
      wr_en   <= 1'b0;
      wr_ack  <= 1'b0;
      din     <= '0;
      afull   <= 1'b0;
      full    <= 1'b0;
    end else begin
      wr_cnt <= wr_cnt_nxt_c;
      afull  <= (wr_cnt_nxt_c >= AW'(254));
      full   <= (wr_cnt_nxt_c == AW'(255));
      wr_en  <= is_wr_c;
      wr_ack <= wr_en;
      if (is_wr_c) begin
        din <= wdata_c;
      end
      if (is_clear_c) begin
        samples <= '0;
      end else if (is_wr_c && (waddr_c > samples)) begin
        samples <= waddr_c;
      end
    end
  end

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ram_q;
  logic [AW-1:0] ptr;

  always_ff @(posedge clk) begin
    if (is_wr_c) begin
      ram[waddr_c] <= wdata_c;
    end
    ram_q <= ram[ptr];
  end

  logic          enable;
  logic          play_vld;
  logic [7:0]    div_cnt;
  logic          tick_c;

  assign tick_c = enable && (div_cnt == 8'd0);

  // Playback: a tick fetches RAM[ptr]; the fetched word lands on wd the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable   <= 1'b0;
      play_vld <= 1'b0;
      ptr      <= '0;
      div_cnt  <= '0;
      wd       <= MIDSCALE;
    end else begin
      if (is_stop_c) begin
        enable   <= 1'b0;
        play_vld <= 1'b0;
      end else if (is_start_c) begin
        enable   <= 1'b1;
        play_vld <= 1'b0;
        ptr      <= '0;
        div_cnt  <= '0;
      end else begin
        play_vld <= tick_c;
        if (tick_c) begin
          ptr     <= (ptr >= samples) ? '0 : ptr + AW'(1);
          div_cnt <= 8'(DIV - 1);
        end else if (div_cnt != 8'd0) begin
          div_cnt <= div_cnt - 8'd1;
        end
      end
      if (is_stop_c || !enable) begin
        wd <= MIDSCALE;
      end else if (play_vld) begin
        wd <= ram_q;
      end
    end
  end

  assign MISO                    = miso_r;
  assign test_rx_valid           = rx_valid;
  assign test_clk_valid          = clk_valid;
  assign test_spi_rx_data        = rx_word;
  assign test_fifo_wr_en         = wr_en;
  assign test_fifo_wr_ack        = wr_ack;
  assign test_fifo_din           = din;
  assign test_fifo_wr_data_count = wr_cnt;
  assign test_count              = {3'b000, bit_cnt};
  assign test_fifo_almost_full   = afull;
  assign test_fifo_full          = full;
  assign test_samples            = samples;
  assign LED_out                 = {full, afull, 4'b0000, clk_valid, enable};

endmodule

// File: tb/tb_eth1_cfgen1.sv
// Bench for eth1_cfgen1: SPI master model, received-word and write-data scoreboards,
// table-driven command vectors plus playback, saturation and reset sequences.
module tb_eth1_cfgen1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SCK;
  logic        MOSI;
  logic        SSEL;
  logic        MISO;
  logic [13:0] wd;
  logic [7:0]  LED_out;
  logic        test_rx_valid;
  logic        test_clk_valid;
  logic [31:0] test_spi_rx_data;
  logic        test_fifo_wr_en;
  logic        test_fifo_wr_ack;
  logic [13:0] test_fifo_din;
  logic [7:0]  test_fifo_wr_data_count;
  logic [7:0]  test_count;
  logic        test_fifo_almost_full;
  logic        test_fifo_full;
  logic [7:0]  test_samples;

  always #5 clk = ~clk;

  eth1_cfgen1 #(.DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .SCK(SCK), .MOSI(MOSI), .SSEL(SSEL), .MISO(MISO),
    .wd(wd), .LED_out(LED_out), .test_rx_valid(test_rx_valid),
    .test_clk_valid(test_clk_valid), .test_spi_rx_data(test_spi_rx_data),
    .test_fifo_wr_en(test_fifo_wr_en), .test_fifo_wr_ack(test_fifo_wr_ack),
    .test_fifo_din(test_fifo_din), .test_fifo_wr_data_count(test_fifo_wr_data_count),
    .test_count(test_count), .test_fifo_almost_full(test_fifo_almost_full),
    .test_fifo_full(test_fifo_full), .test_samples(test_samples)
  );

  typedef struct {
    logic [31:0] word;
    logic [7:0]  cnt;
    logic [7:0]  smp;
    logic [7:0]  led;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rx_q[$];
  logic [13:0] din_q[$];
  logic [31:0] last_word = 32'h0;
  logic        prev_wr_en = 1'b0;
  logic [13:0] sine [24];
  vec_t        vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mkw(input logic [13:0] a, input logic [13:0] d);
    return {4'h1, a, d};
  endfunction

  // Scoreboard side: pop expectations whenever the DUT reports a word or a write
  always @(negedge clk) begin
    if (rst_n) begin
      if (test_rx_valid) begin
        if (rx_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: pulse with word %h, none expected", test_spi_rx_data);
        end else begin
          check("rx_word", test_spi_rx_data, rx_q.pop_front());
        end
      end
      if (test_fifo_wr_en) begin
        if (din_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wr_unexpected: write strobe with din %h, none expected", test_fifo_din);
        end else begin
          check("fifo_din", 32'(test_fifo_din), 32'(din_q.pop_front()));
        end
      end
      if (prev_wr_en || test_fifo_wr_ack)
        check("wr_ack", 32'(test_fifo_wr_ack), 32'(prev_wr_en));
    end
    prev_wr_en = rst_n ? test_fifo_wr_en : 1'b0;
  end

  // SPI master, 3 clk per SCK phase; MISO captured just before each falling edge
  task automatic send_bits(input logic [31:0] w, input int nbits, output logic [31:0] mw);
    mw = 32'h0;
    SSEL = 1'b0;
    #30;
    for (int i = 0; i < nbits; i++) begin
      SCK  = 1'b1;
      MOSI = w[31-i];
      #30;
      mw[31-i] = MISO;
      SCK = 1'b0;
      if (i != nbits - 1) #30;
    end
  endtask

  task automatic wait_rx();
    logic got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = test_rx_valid;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_timeout: no test_rx_valid within 20 cycles");
    end
  endtask

  task automatic xfer(input logic [31:0] w);
    logic [31:0] mw;
    rx_q.push_back(w);
    if (w[31:28] == 4'd1) din_q.push_back(w[13:0]);
    send_bits(w, 32, mw);
    check("miso_echo", mw, last_word);
    last_word = w;
    wait_rx();
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mw;
    int          k;
    logic        seen;

    vecs[0] = '{32'h1000_5FFF, 8'd1, 8'd1, 8'h02};
    vecs[1] = '{32'h1001_4123, 8'd2, 8'd5, 8'h02};
    vecs[2] = '{32'h1040_FABC, 8'd3, 8'd5, 8'h02};
    vecs[3] = '{32'h7123_4567, 8'd3, 8'd5, 8'h02};
    vecs[4] = '{32'h0000_0001, 8'd3, 8'd5, 8'h02};
    vecs[5] = '{32'h4000_0000, 8'd0, 8'd0, 8'h02};
    for (int i = 0; i < 24; i++)
      sine[i] = 14'(8192 + $rtoi(7000.0 * $sin(2.0 * 3.14159265 * (real'(i) + 0.5) / 24.0)));

    rst_n = 1'b0; SCK = 1'b0; MOSI = 1'b0; SSEL = 1'b1;
    #23;
    check("rst_wd", 32'(wd), 32'h2000);
    check("rst_miso", 32'(MISO), 32'h0);
    check("rst_led", 32'(LED_out), 32'h0);
    check("rst_clk_valid", 32'(test_clk_valid), 32'h0);
    check("rst_count", 32'(test_fifo_wr_data_count), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("clk_valid_early", 32'(test_clk_valid), 32'h0);
    @(negedge clk);
    check("clk_valid_16", 32'(test_clk_valid), 32'h1);
    check("idle_wd", 32'(wd), 32'h2000);
    check("idle_led", 32'(LED_out), 32'h02);

    // Command table
    for (int i = 0; i < 6; i++) begin
      xfer(vecs[i].word);
      repeat (2) @(negedge clk);
      check("vec_rx_data", test_spi_rx_data, vecs[i].word);
      check("vec_wr_count", 32'(test_fifo_wr_data_count), 32'(vecs[i].cnt));
      check("vec_samples", 32'(test_samples), 32'(vecs[i].smp));
      check("vec_led", 32'(LED_out), 32'(vecs[i].led));
    end

    // Sine table load and playback
    for (int i = 0; i < 24; i++) xfer(mkw(14'(i), sine[i]));
    repeat (2) @(negedge clk);
    check("sine_count", 32'(test_fifo_wr_data_count), 32'd24);
    check("sine_samples", 32'(test_samples), 32'd23);
    xfer(32'h2000_0000);
    k = 0;
    seen = 1'b0;
    while (k < 10 && !seen) begin
      @(negedge clk);
      k++;
      seen = (wd != 14'h2000);
    end
    check("start_latency", 32'(k), 32'd3);
    check("play_led", 32'(LED_out), 32'h03);
    for (int i = 0; i < 30; i++) begin
      if (i != 0) @(negedge clk);
      check("play_wd", 32'(wd), 32'(sine[i % 24]));
    end

    xfer(32'h3000_0000);
    @(negedge clk);
    check("stop_wd", 32'(wd), 32'h2000);
    check("stop_led", 32'(LED_out), 32'h02);
    repeat (5) @(negedge clk);
    check("stop_wd_hold", 32'(wd), 32'h2000);

    // Partial word aborted by SSEL, then a clean word
    SSEL = 1'b1;
    repeat (5) @(negedge clk);
    send_bits(32'hA5A5_0000, 17, mw);
    repeat (4) @(negedge clk);
    check("partial_count", 32'(test_count), 32'd17);
    SSEL = 1'b1;
    repeat (4) @(negedge clk);
    check("ssel_count_clear", 32'(test_count), 32'd0);
    check("ssel_miso", 32'(MISO), 32'h0);
    xfer(32'h7ABC_DEF0);
    repeat (2) @(negedge clk);
    check("after_partial_data", test_spi_rx_data, 32'h7ABC_DEF0);

    // Write-count saturation and fill flags
    xfer(32'h4000_0000);
    for (int i = 0; i < 254; i++) xfer(mkw(14'(i), 14'(i * 37)));
    repeat (2) @(negedge clk);
    check("cnt_254", 32'(test_fifo_wr_data_count), 32'd254);
    check("afull_254", 32'(test_fifo_almost_full), 32'h1);
    check("full_254", 32'(test_fifo_full), 32'h0);
    check("led_254", 32'(LED_out), 32'h42);
    xfer(mkw(14'd254, 14'h0AAA));
    repeat (2) @(negedge clk);
    check("cnt_255", 32'(test_fifo_wr_data_count), 32'd255);
    check("full_255", 32'(test_fifo_full), 32'h1);
    check("led_255", 32'(LED_out), 32'hC2);
    xfer(mkw(14'h3FFF, 14'h1555));
    repeat (2) @(negedge clk);
    check("cnt_sat", 32'(test_fifo_wr_data_count), 32'd255);
    check("samples_255", 32'(test_samples), 32'd255);
    xfer(32'h4000_0000);
    repeat (2) @(negedge clk);
    check("clear_cnt", 32'(test_fifo_wr_data_count), 32'd0);
    check("clear_flags", 32'({test_fifo_full, test_fifo_almost_full}), 32'h0);
    check("clear_samples", 32'(test_samples), 32'd0);

    // Reset in the middle of a word
    SSEL = 1'b1;
    repeat (5) @(negedge clk);
    send_bits(32'hFFFF_FFFF, 10, mw);
    repeat (4) @(negedge clk);
    check("mid_count", 32'(test_count), 32'd10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_count", 32'(test_count), 32'd0);
    check("async_rx_data", test_spi_rx_data, 32'h0);
    check("async_led", 32'(LED_out), 32'h0);
    check("async_wd", 32'(wd), 32'h2000);
    SCK = 1'b0;
    SSEL = 1'b1;
    last_word = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (16) @(negedge clk);
    check("reboot_clk_valid", 32'(test_clk_valid), 32'h1);
    xfer(32'h7000_0001);
    repeat (2) @(negedge clk);

    check("rx_q_drained", 32'(rx_q.size()), 32'd0);
    check("din_q_drained", 32'(din_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
